// File: rtl/cdf_map_generator.sv
// Walks a 256-bin tile histogram one bin per clock, accumulates the CDF and scales it into an 8-bit equalization LUT.
// Optional contrast limiting (clip + redistribute) is compiled in with `define CDF_CLIP_LIMIT_EN.
module cdf_map_generator #(
    parameter int N_PIXELS   = 2025,
    parameter int BIN_W      = 11,
    parameter int CDF_W      = 12,
    parameter int RECIP      = 33011,
    parameter int SHIFT      = 18,
    parameter int CLIP_LIMIT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 map_start,
    input  logic [BIN_W*256-1:0] Count,
    output logic                 map_busy,
    output logic                 map_done,
    output logic                 map_valid,
    output logic [8*256-1:0]     map_lut,
    output logic [CDF_W-1:0]     cdf_total
);
    localparam int PROD_W = 28;
    localparam logic [CDF_W-1:0] CDF_MAX = '1;

    typedef enum logic [1:0] {IDLE, CLIP, ACCUM, DONE} state_t;

    state_t           state_q, state_d;
    logic [7:0]       idx_q, idx_d;
    logic [CDF_W-1:0] cdf_q, cdf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             valid_q, valid_d;
    logic [8*256-1:0] lut_q, lut_d;
    logic [CDF_W-1:0] total_q, total_d;

    logic [BIN_W-1:0]  bin_raw;
    logic [CDF_W-1:0]  bin_eff;
    logic [CDF_W:0]    cdf_sum;
    logic [CDF_W-1:0]  cdf_new;
    logic [PROD_W-1:0] product;
    logic [PROD_W-1:0] scaled;
    logic [7:0]        lut_val;

`ifdef CDF_CLIP_LIMIT_EN
    localparam int EXC_W = BIN_W + 8;
    localparam logic [BIN_W-1:0] CLIP_BIN = BIN_W'(CLIP_LIMIT);
    logic [EXC_W-1:0] excess_q, excess_d;
`endif

    // Datapath for the bin currently addressed by idx_q: effective bin, saturating CDF, scaled LUT value.
    always_comb begin
        bin_raw = Count[int'(idx_q)*BIN_W +: BIN_W];
`ifdef CDF_CLIP_LIMIT_EN
        // Clipped mass is spread evenly, with the remainder going one pixel each to the lowest bins.
        bin_eff = ((bin_raw > CLIP_BIN) ? CDF_W'(CLIP_BIN) : CDF_W'(bin_raw))
                + CDF_W'(excess_q >> 8)
                + ((idx_q < excess_q[7:0]) ? CDF_W'(1) : CDF_W'(0));
`else
        bin_eff = CDF_W'(bin_raw);
`endif
        cdf_sum = {1'b0, cdf_q} + {1'b0, bin_eff};
        cdf_new = cdf_sum[CDF_W] ? CDF_MAX : cdf_sum[CDF_W-1:0];
        product = PROD_W'(cdf_new) * PROD_W'(RECIP);
        scaled  = product >> SHIFT;
        lut_val = (|scaled[PROD_W-1:8]) ? 8'hFF : scaled[7:0];
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cdf_d   = cdf_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        valid_d = valid_q;
        lut_d   = lut_q;
        total_d = total_q;
`ifdef CDF_CLIP_LIMIT_EN
        excess_d = excess_q;
`endif
        case (state_q)
            IDLE: begin
                if (map_start) begin
                    idx_d   = 8'd0;
                    cdf_d   = '0;
                    valid_d = 1'b0;
                    busy_d  = 1'b1;
`ifdef CDF_CLIP_LIMIT_EN
                    excess_d = '0;
                    state_d  = CLIP;
`else
                    state_d = ACCUM;
`endif
                end
            end
`ifdef CDF_CLIP_LIMIT_EN
            CLIP: begin
                if (bin_raw > CLIP_BIN) begin
                    excess_d = excess_q + EXC_W'(bin_raw - CLIP_BIN);
                end
                idx_d = idx_q + 8'd1;
                if (idx_q == 8'hFF) begin
                    state_d = ACCUM;
                end
            end
`endif
            ACCUM: begin
                cdf_d = cdf_new;
                lut_d[int'(idx_q)*8 +: 8] = lut_val;
                idx_d = idx_q + 8'd1;
                if (idx_q == 8'hFF) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                valid_d = 1'b1;
                busy_d  = 1'b0;
                total_d = cdf_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= 8'd0;
            cdf_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            lut_q   <= '0;
            total_q <= '0;
`ifdef CDF_CLIP_LIMIT_EN
            excess_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cdf_q   <= cdf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            valid_q <= valid_d;
            lut_q   <= lut_d;
            total_q <= total_d;
`ifdef CDF_CLIP_LIMIT_EN
            excess_q <= excess_d;
`endif
        end
    end

    assign map_busy  = busy_q;
    assign map_done  = done_q;
    assign map_valid = valid_q;
    assign map_lut   = lut_q;
    assign cdf_total = total_q;

endmodule

// File: doc/cdf_map_generator.md
# cdf_map_generator

Consumes the 256-bin packed histogram produced by the tile histogram stage. It walks the bins sequentially, one per clock, and builds the cumulative distribution. Each cumulative value is scaled to an 8-bit output intensity, producing a 256-entry equalization mapping LUT that the pixel remap stage reads. It sits between the histogram stage (its `hist_completed` drives `map_start`) and the per-pixel intensity remapper of the local contrast enhancement pipeline.

## Interface
- `N_PIXELS`, 2025: pixels per tile; expected histogram total.
- `BIN_W`, 11: width of one histogram bin.
- `CDF_W`, 12: cumulative accumulator width.
- `RECIP`, 33011: scale constant, round(255·2^SHIFT/N_PIXELS).
- `SHIFT`, 18: right shift applied after the multiply by `RECIP`.
- `CLIP_LIMIT`, 64: per-bin clip ceiling; used only with `CDF_CLIP_LIMIT_EN`.

Ports:
- `clk` input 1: clock, rising edge.
- `rst` input 1: synchronous reset, active-high.
- `map_start` input 1: start request; sampled only in IDLE.
- `Count` input 11*256: packed histogram, bin k at `[k*11 +: 11]`. Must stay stable while `map_busy`=1.
- `map_busy` output 1: high from the cycle after start is accepted until `map_done`.
- `map_done` output 1: one-cycle pulse when the LUT is complete.
- `map_valid` output 1: LUT valid. Set with `map_done`; cleared when the next start is accepted.
- `map_lut` output 8*256: packed LUT, entry k at `[k*8 +: 8]`.
- `cdf_total` output 12: final accumulator value, for checking against `N_PIXELS`.

## Operation
- States: IDLE, CLIP (only with `CDF_CLIP_LIMIT_EN`), ACCUM, DONE.
- IDLE + `map_start`=1:
  - clear the bin index, accumulator, `map_valid` and excess counter;
  - go to CLIP if the feature is enabled, otherwise ACCUM.
- ACCUM: per cycle, bin k = index.
  - `cdf = sat(cdf + bin'(k))`, where bin' is the raw bin, or the clipped bin when clipping is enabled.
  - `map_lut[k] = min(255, (cdf_new * RECIP) >> SHIFT)`. Use a 28-bit product and floor rounding.
  - The LUT is monotonic non-decreasing by construction.
  - After k=255, go to DONE.
- DONE:
  - pulse `map_done`, set `map_valid`, latch `cdf_total`;
  - return to IDLE next cycle.
- Accumulator saturates at 4095 and never wraps. An oversized histogram (not cleared upstream) therefore yields 255 entries, not garbage.
- `map_start` while busy or in DONE is ignored; no queuing.
- `map_lut` entries not yet rewritten keep their previous values during a run. Consumers use `map_valid` only.

## Timing
- Reset values: `map_busy`=0, `map_done`=0, `map_valid`=0, `map_lut`=0, `cdf_total`=0, state IDLE.
- Start accepted at edge T: `map_busy`=1 from T+1.
- Latency without clip: LUT entry k written at edge T+1+k. `map_done` is high in cycle T+257, with `map_busy` dropping at the same edge.
- Latency with clip: a 256-cycle CLIP pass precedes ACCUM, so `map_done` is high in cycle T+513.
- Back-to-back: a new start is accepted in the first IDLE cycle after `map_done`.
- `rst` mid-run: next edge returns to IDLE with all outputs at their reset values. The partial LUT is discarded (zeroed).

## Configuration
- Macro `CDF_CLIP_LIMIT_EN`.
- Defined: contrast-limited mode.
  - CLIP pass: `excess += max(0, Count[k] − CLIP_LIMIT)` for k=0..255.
  - In ACCUM, bin' = `min(Count[k], CLIP_LIMIT) + (excess >> 8) + (k < (excess & 255) ? 1 : 0)`.
  - Total is preserved, so `cdf_total` = `N_PIXELS` for a valid histogram.
- Not defined: no CLIP state, no excess logic, bin' = `Count[k]`, 257-cycle latency. `CLIP_LIMIT` is unused.

## Test plan
- Count[0]=2025, all other bins 0, no clip → all 256 entries = 255; `cdf_total`=2025; `map_done` at T+257.
- Count[255]=2025 only → entries 0..254 = 0, entry 255 = 255.
- Count[0]=1025, Count[128]=1000 → entries 0..127 = 129, entries 128..255 = 255.
- `map_start` pulsed at T+50 of a run, then `rst` at T+100 → the mid-run start is ignored (single `map_done` when no reset is applied). After the reset, all outputs are 0 and the state is IDLE.
- `CDF_CLIP_LIMIT_EN`, CLIP_LIMIT=64, Count[0]=2025 → excess 1961, clipped bins 72 / 8 (k=1..168) / 7 (k=169..255). Entry 0 = 9, entry 255 = 255, `cdf_total`=2025, `map_done` at T+513.
- All bins = 2047 (overflow) → accumulator saturates at 4095; `map_lut` never decreases and ends at 255; `cdf_total`=4095.
